// File: rtl/apb_xfer_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_xfer_sequencer: splits one AHB request into APB beats, gathers reads  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module apb_xfer_sequencer #(
  parameter int AHB_AW  = 32,
  parameter int AHB_DW  = 32,
  parameter int APB_AW  = 32,
  parameter int APB_DW  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              i_start,
  input  logic [AHB_AW-1:0] i_HADDR,
  input  logic [2:0]        i_HSIZE,
  input  logic              i_HWRITE,
  input  logic [AHB_DW-1:0] i_HWDATA,
  output logic [APB_AW-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [APB_DW-1:0] PWDATA,
  input  logic [APB_DW-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic              o_timeout,
  output logic [AHB_DW-1:0] o_rdata
);

  localparam int c_BPB  = APB_DW / 8;
  localparam int c_BSH  = $clog2(c_BPB);
  localparam int c_MAXB = AHB_DW / APB_DW;
  localparam int c_BW   = (c_MAXB > 1) ? $clog2(c_MAXB) : 1;
  localparam int c_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_CW-1:0] c_TO_LAST = c_CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [c_BW-1:0]     r_beat;
  logic [c_BW-1:0]     r_last;
  logic [c_CW-1:0]     r_cnt;
  logic [APB_AW-1:0]   r_paddr;
  logic [AHB_DW-1:0]   r_wsh;
  logic                r_pwrite;
  logic                r_psel;
  logic                r_penable;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic                r_to;
  logic [AHB_DW-1:0]   r_rdata;

  logic [1:0]          w_size;
  logic [c_BW-1:0]     w_last;
  logic [c_BW-1:0]     w_beat_nxt;
  logic [c_CW-1:0]     w_cnt_nxt;
  logic                w_accept;
  logic                w_advance;
  logic                w_capture;
  logic                w_set_err;
  logic                w_set_to;

  // Beats per request = access bytes / APB bytes, never below one.
  assign w_size = (i_HSIZE > 3'd2) ? 2'd2 : i_HSIZE[1:0];
  assign w_last = (int'(w_size) > c_BSH) ? c_BW'((1 << (int'(w_size) - c_BSH)) - 1) : '0;

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_beat_nxt = r_beat;
    w_cnt_nxt  = r_cnt;
    w_accept   = 1'b0;
    w_advance  = 1'b0;
    w_capture  = 1'b0;
    w_set_err  = 1'b0;
    w_set_to   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_accept   = 1'b1;
          w_next     = S_SETUP;
          w_beat_nxt = '0;
          w_cnt_nxt  = '0;
        end
      end
      S_SETUP: begin
        w_next    = S_ACCESS;
        w_cnt_nxt = '0;
      end
      S_ACCESS: begin
        if (PREADY) begin
          w_capture = 1'b1;
          if (PSLVERR) begin
            w_set_err = 1'b1;
            w_next    = S_DONE;
          end else if (r_beat == r_last) begin
            w_next = S_DONE;
          end else begin
            w_advance  = 1'b1;
            w_beat_nxt = r_beat + 1'b1;
            w_next     = S_SETUP;
          end
        end else if ((TIMEOUT != 0) && (r_cnt == c_TO_LAST)) begin
          w_set_err = 1'b1;
          w_set_to  = 1'b1;
          w_next    = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // APB/status outputs are registered from the next state so they line up with it.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_beat    <= '0;
      r_last    <= '0;
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_wsh     <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_to      <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_psel    <= (w_next == S_SETUP) || (w_next == S_ACCESS);
      r_penable <= (w_next == S_ACCESS);
      r_busy    <= (w_next != S_IDLE);
      r_done    <= (w_next == S_DONE);
      r_beat    <= w_beat_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_accept) begin
        r_paddr  <= i_HADDR[APB_AW-1:0];
        r_wsh    <= i_HWDATA;
        r_pwrite <= i_HWRITE;
        r_last   <= w_last;
        r_err    <= 1'b0;
        r_to     <= 1'b0;
        r_rdata  <= '0;
      end
      if (w_advance) begin
        r_paddr <= r_paddr + APB_AW'(c_BPB);
        r_wsh   <= r_wsh >> APB_DW;
      end
      if (w_set_err) r_err <= 1'b1;
      if (w_set_to)  r_to  <= 1'b1;
      if (w_capture && !r_pwrite) begin
        for (int i = 0; i < c_MAXB; i++) begin
          if (int'(r_beat) == i) r_rdata[i*APB_DW +: APB_DW] <= PRDATA;
        end
      end
    end
  end

  assign PADDR     = r_paddr;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_wsh[APB_DW-1:0];
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_error   = r_err;
  assign o_timeout = r_to;
  assign o_rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_xfer_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_apb_xfer_sequencer: bench for apb_xfer_sequencer (8-bit APB, TO=16)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_apb_xfer_sequencer;

  localparam int TO = 16;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_HADDR = '0;
  logic [2:0]  i_HSIZE = '0;
  logic        i_HWRITE = 1'b0;
  logic [31:0] i_HWDATA = '0;
  logic [31:0] PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PWDATA;
  logic [7:0]  PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;
  logic        o_busy, o_done, o_error, o_timeout;
  logic [31:0] o_rdata;

  always #5 HCLK = ~HCLK;

  apb_xfer_sequencer #(
    .AHB_AW(32), .AHB_DW(32), .APB_AW(32), .APB_DW(8), .TIMEOUT(TO)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .i_start(i_start), .i_HADDR(i_HADDR),
    .i_HSIZE(i_HSIZE), .i_HWRITE(i_HWRITE), .i_HWDATA(i_HWDATA),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .o_timeout(o_timeout), .o_rdata(o_rdata)
  );

  typedef struct {
    logic        sel;
    logic        en;
    logic        wr;
    logic        done;
    logic [31:0] addr;
    logic [7:0]  wd;
    logic [31:0] rd;
    logic        err;
    logic        to;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;
  logic [31:0] held_rd = '0;
  logic        held_err = 1'b0;
  logic        held_to = 1'b0;
  int          w_tbl[4];
  logic [7:0]  rd_tbl[4];
  int          err_beat = -1;
  int          obs_setup, obs_access, obs_busy, obs_busy_done;
  bit          obs_done_seen;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // APB slave: beat k holds PREADY low for w_tbl[k] ACCESS cycles, errors on err_beat.
  initial begin : slave
    int  s_beat;
    int  s_cnt;
    bit  s_in;
    bit  s_hs;
    s_beat = 0; s_cnt = 0; s_in = 0; s_hs = 0;
    forever begin
      @(negedge HCLK);
      if (PSEL !== 1'b1) begin
        s_beat = 0; s_hs = 0; s_in = 0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      end else begin
        if (s_hs) begin
          s_beat++;
          s_hs = 0;
        end
        if (PENABLE === 1'b1) begin
          if (!s_in) begin
            s_in  = 1;
            s_cnt = 0;
          end else begin
            s_cnt++;
          end
          PREADY  = (s_cnt >= w_tbl[s_beat & 3]);
          PRDATA  = rd_tbl[s_beat & 3];
          PSLVERR = PREADY && (s_beat == err_beat);
          if (PREADY) begin
            s_hs = 1;
            s_in = 0;
          end
        end else begin
          PREADY = 1'b0; PSLVERR = 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the expected phase trace.
  initial begin : compare
    exp_t e;
    forever begin
      @(posedge HCLK);
      #1;
      if (chk_en) begin
        if (o_busy === 1'b1) obs_busy++;
        if (PSEL === 1'b1 && PENABLE === 1'b0) obs_setup++;
        if (PSEL === 1'b1 && PENABLE === 1'b1) obs_access++;
        if (o_done === 1'b1) begin
          obs_busy_done = obs_busy;
          obs_done_seen = 1'b1;
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("psel", PSEL, e.sel);
          chk("penable", PENABLE, e.en);
          chk("done", o_done, e.done);
          chk("busy", o_busy, 1'b1);
          if (e.sel) begin
            chk("paddr", PADDR, e.addr);
            chk("pwrite", PWRITE, e.wr);
            if (e.wr) chk("pwdata", PWDATA, e.wd);
          end
          if (e.done) begin
            chk("rdata", o_rdata, e.rd);
            chk("error", o_error, e.err);
            chk("timeout", o_timeout, e.to);
            held_rd  = e.rd;
            held_err = e.err;
            held_to  = e.to;
          end
        end else begin
          chk("idle_psel", PSEL, 1'b0);
          chk("idle_penable", PENABLE, 1'b0);
          chk("idle_done", o_done, 1'b0);
          chk("idle_busy", o_busy, 1'b0);
          chk("idle_rdata", o_rdata, held_rd);
          chk("idle_error", o_error, held_err);
          chk("idle_timeout", o_timeout, held_to);
        end
      end
    end
  end

  task automatic push_phase(input logic en, input logic wr, input logic [31:0] a, input logic [7:0] wd);
    exp_t e;
    e.sel = 1'b1; e.en = en; e.wr = wr; e.done = 1'b0;
    e.addr = a; e.wd = wd; e.rd = '0; e.err = 1'b0; e.to = 1'b0;
    q.push_back(e);
  endtask

  // Expected trace: per beat one SETUP then (waits+1) ACCESS cycles, capped by TO.
  task automatic build_model(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                             input logic [31:0] wdat);
    exp_t        e;
    int          nb;
    logic [31:0] rdv;
    logic [31:0] sh;
    logic        er;
    logic        tm;
    nb  = 1 << ((sz > 3'd2) ? 2 : int'(sz));
    rdv = '0; er = 1'b0; tm = 1'b0;
    for (int k = 0; k < nb; k++) begin
      sh = wdat >> (8 * k);
      push_phase(1'b0, wr, a + k, sh[7:0]);
      if (w_tbl[k] >= TO) begin
        for (int c = 0; c < TO; c++) push_phase(1'b1, wr, a + k, sh[7:0]);
        er = 1'b1; tm = 1'b1;
        break;
      end
      for (int c = 0; c <= w_tbl[k]; c++) push_phase(1'b1, wr, a + k, sh[7:0]);
      if (!wr) rdv[8*k +: 8] = rd_tbl[k];
      if (k == err_beat) begin
        er = 1'b1;
        break;
      end
    end
    e.sel = 1'b0; e.en = 1'b0; e.wr = wr; e.done = 1'b1;
    e.addr = '0; e.wd = '0; e.rd = rdv; e.err = er; e.to = tm;
    q.push_back(e);
  endtask

  task automatic start_xfer(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                            input logic [31:0] wdat, input int w0, input int w1, input int w2,
                            input int w3, input logic [31:0] rds, input int eb);
    @(negedge HCLK);
    w_tbl[0] = w0; w_tbl[1] = w1; w_tbl[2] = w2; w_tbl[3] = w3;
    rd_tbl[0] = rds[7:0]; rd_tbl[1] = rds[15:8]; rd_tbl[2] = rds[23:16]; rd_tbl[3] = rds[31:24];
    err_beat = eb;
    i_HADDR = a; i_HSIZE = sz; i_HWRITE = wr; i_HWDATA = wdat;
    i_start = 1'b1;
    obs_setup = 0; obs_access = 0; obs_busy = 0; obs_busy_done = 0; obs_done_seen = 1'b0;
    build_model(a, sz, wr, wdat);
    @(negedge HCLK);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge HCLK);
    chk({nm, "_finished"}, q.size(), 0);
    q.delete();
  endtask

  task automatic run_xfer(input string nm, input logic [31:0] a, input logic [2:0] sz,
                          input logic wr, input logic [31:0] wdat, input int w0, input int w1,
                          input int w2, input int w3, input logic [31:0] rds, input int eb);
    start_xfer(a, sz, wr, wdat, w0, w1, w2, w3, rds, eb);
    wait_done(nm);
  endtask

  initial begin : stim
    for (int i = 0; i < 4; i++) begin
      w_tbl[i]  = 0;
      rd_tbl[i] = '0;
    end
    repeat (3) @(negedge HCLK);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 8'h0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_error", o_error, 1'b0);
    chk("rst_timeout", o_timeout, 1'b0);
    chk("rst_rdata", o_rdata, 32'h0);
    HRESET = 1'b0;
    chk_en = 1'b1;

    run_xfer("t1", 32'h100, 3'd2, 1'b0, 32'h0, 0, 0, 0, 0, 32'h44332211, -1);
    chk("t1_rdata", o_rdata, 32'h44332211);
    chk("t1_done_cycle", obs_busy_done, 9);
    chk("t1_setups", obs_setup, 4);
    chk("t1_error", o_error, 1'b0);

    run_xfer("t2", 32'h20, 3'd1, 1'b1, 32'h0000BEEF, 0, 0, 0, 0, 32'h0, -1);
    chk("t2_setups", obs_setup, 2);
    chk("t2_done_cycle", obs_busy_done, 5);
    chk("t2_rdata", o_rdata, 32'h0);

    run_xfer("t3", 32'h40, 3'd2, 1'b0, 32'h0, 0, 3, 0, 0, 32'hDDCCBBAA, -1);
    chk("t3_access", obs_access, 7);
    chk("t3_done_cycle", obs_busy_done, 12);
    chk("t3_rdata", o_rdata, 32'hDDCCBBAA);

    run_xfer("t4", 32'h80, 3'd2, 1'b0, 32'h0, 0, 0, 0, 0, 32'h04030201, 1);
    chk("t4_setups", obs_setup, 2);
    chk("t4_error", o_error, 1'b1);
    chk("t4_timeout", o_timeout, 1'b0);
    chk("t4_rdata", o_rdata, 32'h00000201);

    run_xfer("t5", 32'h300, 3'd0, 1'b0, 32'h0, 16, 0, 0, 0, 32'h5A, -1);
    chk("t5_access", obs_access, 16);
    chk("t5_error", o_error, 1'b1);
    chk("t5_timeout", o_timeout, 1'b1);
    chk("t5_done_cycle", obs_busy_done, 18);

    run_xfer("t5b", 32'h301, 3'd0, 1'b0, 32'h0, 15, 0, 0, 0, 32'h5A, -1);
    chk("t5b_access", obs_access, 16);
    chk("t5b_timeout", o_timeout, 1'b0);
    chk("t5b_rdata", o_rdata, 32'h0000005A);

    run_xfer("t7", 32'hFFFFFFFE, 3'd3, 1'b1, 32'h12345678, 1, 0, 2, 0, 32'h0, -1);
    chk("t7_setups", obs_setup, 4);
    chk("t7_error", o_error, 1'b0);

    // Reset lands during ACCESS of the second beat.
    start_xfer(32'h500, 3'd2, 1'b0, 32'h0, 0, 6, 0, 0, 32'h87654321, -1);
    repeat (3) @(negedge HCLK);
    chk("t6_in_access", PSEL && PENABLE, 1'b1);
    HRESET = 1'b1;
    q.delete();
    held_rd = '0; held_err = 1'b0; held_to = 1'b0;
    @(negedge HCLK);
    chk("t6_psel", PSEL, 1'b0);
    chk("t6_penable", PENABLE, 1'b0);
    chk("t6_busy", o_busy, 1'b0);
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("t6_no_done", obs_done_seen, 1'b0);

    run_xfer("t6b", 32'h600, 3'd2, 1'b0, 32'h0, 0, 1, 0, 0, 32'hCAFEF00D, -1);
    chk("t6b_rdata", o_rdata, 32'hCAFEF00D);
    chk("t6b_error", o_error, 1'b0);

    repeat (3) @(negedge HCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
